// File: rtl/tape_symbol_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tape_symbol_encoder
// Purpose  : Repacks a framed byte stream into 4-bit tape symbols for the
//            composite video output FIFO. Each frame is written as
//            SOF preamble, payload symbols, 3 checksum symbols, EOF postamble.
//            Only the 10-code alphabet (8 data codes + SOF + EOF) is written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk               in   125 MHz eth_mgr clock
//   rst               in   synchronous active-high reset
//   s_data[7:0]       in   payload byte (held stable until accepted)
//   s_valid           in   s_data valid
//   s_last            in   marks final byte of a frame
//   s_ready           out  byte accepted when s_valid && s_ready at posedge
//   fifow_data[3:0]   out  registered symbol to FIFO
//   fifow_request     out  registered FIFO write strobe, one symbol per cycle
//   fifow_used_words  in   FIFO fill level (write-clock domain)
// ----------------------------------------------------------------------------
// Build option:
//   TAPE_ENC_CRC8_EN  defined   -> checksum is CRC-8 (poly 0x07, init 0x00,
//                                  MSB-first, no reflection, no final XOR)
//                     undefined -> checksum is the 8-bit sum of payload bytes
// ============================================================================
module tape_symbol_encoder #(
    parameter int PREAMBLE_LEN    = 8,
    parameter int POSTAMBLE_LEN   = 2,
    parameter int FIFO_HIGH_WATER = 2040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [3:0]  fifow_data,
    output logic        fifow_request,
    input  logic [10:0] fifow_used_words
);

    localparam logic [3:0]  c_SOF        = 4'b1010;
    localparam logic [3:0]  c_EOF        = 4'b0101;
    localparam logic [7:0]  c_PRE_LAST   = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  c_POST_LAST  = 8'(POSTAMBLE_LEN - 1);
    localparam logic [10:0] c_HIGH_WATER = 11'(FIFO_HIGH_WATER);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PAY  = 3'd2,
        ST_PAD  = 3'd3,
        ST_CSUM = 3'd4,
        ST_POST = 3'd5
    } state_t;

    // 3-bit value to tape code: a thermometer-like walk so adjacent values
    // differ in a single bit on tape.
    function automatic logic [3:0] f_map(input logic [2:0] v);
        logic [3:0] r;
        case (v)
            3'd0:    r = 4'b0000;
            3'd1:    r = 4'b0001;
            3'd2:    r = 4'b0011;
            3'd3:    r = 4'b0111;
            3'd4:    r = 4'b1111;
            3'd5:    r = 4'b1110;
            3'd6:    r = 4'b1100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] f_csum_next(input logic [7:0] c, input logic [7:0] b);
`ifdef TAPE_ENC_CRC8_EN
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
`else
        return c + b;
`endif
    endfunction

    state_t      r_state;
    logic [9:0]  r_acc;        // left-justified: valid bits occupy r_acc[9 -: r_acc_cnt]
    logic [3:0]  r_acc_cnt;
    logic [7:0]  r_csum;
    logic        r_last_seen;
    logic [7:0]  r_cnt;        // preamble / checksum / postamble symbol index

    state_t      w_state_nxt;
    logic [9:0]  w_acc_nxt;
    logic [3:0]  w_acc_cnt_nxt;
    logic [7:0]  w_csum_nxt;
    logic        w_last_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_emit;
    logic [3:0]  w_sym;
    logic        w_ready;
    logic        w_room;
    logic [9:0]  w_byte_aligned;
    logic [8:0]  w_csum9;

    assign w_room  = (fifow_used_words < c_HIGH_WATER);
    assign w_csum9 = {1'b0, r_csum};
    assign s_ready = w_ready;

    // Place the incoming byte directly below the bits still in the
    // accumulator (acc_cnt is 0..2 whenever a byte can be accepted).
    always_comb begin
        w_byte_aligned = 10'd0;
        case (r_acc_cnt[1:0])
            2'd0:    w_byte_aligned = {s_data, 2'b00};
            2'd1:    w_byte_aligned = {1'b0, s_data, 1'b0};
            default: w_byte_aligned = {2'b00, s_data};
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_acc_cnt_nxt = r_acc_cnt;
        w_csum_nxt    = r_csum;
        w_last_nxt    = r_last_seen;
        w_cnt_nxt     = r_cnt;
        w_emit        = 1'b0;
        w_sym         = 4'b0000;
        w_ready       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Byte is only noted here; it is consumed later in PAY.
                if (s_valid) begin
                    w_state_nxt   = ST_PRE;
                    w_cnt_nxt     = 8'd0;
                    w_csum_nxt    = 8'd0;
                    w_last_nxt    = 1'b0;
                    w_acc_nxt     = 10'd0;
                    w_acc_cnt_nxt = 4'd0;
                end
            end

            ST_PRE: begin
                if (w_room) begin
                    w_emit = 1'b1;
                    w_sym  = c_SOF;
                    if (r_cnt == c_PRE_LAST) begin
                        w_state_nxt = ST_PAY;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end

            ST_PAY: begin
                w_ready = (r_acc_cnt < 4'd3) && !r_last_seen;
                if (w_ready && s_valid) begin
                    w_acc_nxt     = r_acc | w_byte_aligned;
                    w_acc_cnt_nxt = r_acc_cnt + 4'd8;
                    w_csum_nxt    = f_csum_next(r_csum, s_data);
                    w_last_nxt    = s_last;
                end else if (r_acc_cnt >= 4'd3) begin
                    if (w_room) begin
                        w_emit        = 1'b1;
                        w_sym         = f_map(r_acc[9:7]);
                        w_acc_nxt     = {r_acc[6:0], 3'b000};
                        w_acc_cnt_nxt = r_acc_cnt - 4'd3;
                    end
                end else if (r_last_seen) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = (r_acc_cnt != 4'd0) ? ST_PAD : ST_CSUM;
                end
            end

            ST_PAD: begin
                // Bits below the leftovers were shifted in as zeros.
                if (w_room) begin
                    w_emit        = 1'b1;
                    w_sym         = f_map(r_acc[9:7]);
                    w_acc_nxt     = 10'd0;
                    w_acc_cnt_nxt = 4'd0;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = ST_CSUM;
                end
            end

            ST_CSUM: begin
                if (w_room) begin
                    w_emit = 1'b1;
                    case (r_cnt[1:0])
                        2'd0:    w_sym = f_map(w_csum9[8:6]);
                        2'd1:    w_sym = f_map(w_csum9[5:3]);
                        default: w_sym = f_map(w_csum9[2:0]);
                    endcase
                    if (r_cnt == 8'd2) begin
                        w_state_nxt = ST_POST;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end

            ST_POST: begin
                if (w_room) begin
                    w_emit = 1'b1;
                    w_sym  = c_EOF;
                    if (r_cnt == c_POST_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 8'd0;
                        w_csum_nxt  = 8'd0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_acc         <= 10'd0;
            r_acc_cnt     <= 4'd0;
            r_csum        <= 8'd0;
            r_last_seen   <= 1'b0;
            r_cnt         <= 8'd0;
            fifow_request <= 1'b0;
            fifow_data    <= 4'b0000;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_acc_cnt     <= w_acc_cnt_nxt;
            r_csum        <= w_csum_nxt;
            r_last_seen   <= w_last_nxt;
            r_cnt         <= w_cnt_nxt;
            fifow_request <= w_emit;
            // Data holds its last written code on non-write cycles.
            if (w_emit) begin
                fifow_data <= w_sym;
            end
        end
    end

endmodule
`default_nettype wire
